// File: rtl/thumb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// thumb_fetch_ctrl : Thumb IF-stage fetch PC, single-outstanding IMEM request,
//                    2-entry halfword queue toward decode.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module thumb_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] PC,
    input  logic [31:0] NPC,
    output logic        PC_REL_SEL,
    output logic [31:0] PC_REL_OFFSET,
    input  logic        BR_REQ,
    input  logic [31:0] BR_OFFSET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RDY,
    input  logic [15:0] IMEM_RDATA,
    output logic        IF_VALID,
    output logic [15:0] IF_INST,
    output logic [31:0] IF_PC,
    input  logic        ID_READY,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    localparam logic [31:0] C_RESET_PC = {RESET_PC[31:1], 1'b0};

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] fifo_addr_q [2];
    logic [15:0] fifo_inst_q [2];
    logic [1:0]  cnt_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;

    logic        w_req;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_cnt_after_pop;
    logic [1:0]  cnt_d;
    logic [31:0] w_target;

    assign w_req           = (state_q == S_FETCH) || (state_q == S_KILL);
    assign w_pop           = IF_VALID & ID_READY & ~BR_REQ;
    assign w_push          = (state_q == S_FETCH) & IMEM_RDY & ~BR_REQ;
    assign w_cnt_after_pop = cnt_q - {1'b0, w_pop};
    assign cnt_d           = w_cnt_after_pop + {1'b0, w_push};
    assign w_target        = {NPC[31:1], 1'b0};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_RESET;
            pc_q     <= C_RESET_PC;
            addr_q   <= C_RESET_PC;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (w_push) begin
                fifo_addr_q[wr_ptr_q] <= addr_q;
                fifo_inst_q[wr_ptr_q] <= IMEM_RDATA;
            end

            // A redirect wipes the queue; any same-cycle push/pop is moot.
            if (BR_REQ) begin
                cnt_q    <= 2'd0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                if (w_push) wr_ptr_q <= ~wr_ptr_q;
                if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
            end

            case (state_q)
                S_RESET: begin
                    if (BR_REQ) begin
                        pc_q   <= w_target;
                        addr_q <= w_target;
                    end
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (BR_REQ) begin
                        pc_q <= w_target;
                        if (!IMEM_RDY) begin
                            state_q <= S_KILL;
                        end else begin
                            addr_q  <= w_target;
                            state_q <= S_FETCH;
                        end
                    end else if (IMEM_RDY) begin
                        pc_q    <= NPC;
                        addr_q  <= NPC;
                        state_q <= (cnt_d < 2'd2) ? S_FETCH : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (BR_REQ) begin
                        pc_q    <= w_target;
                        addr_q  <= w_target;
                        state_q <= S_FETCH;
                    end else if (w_cnt_after_pop < 2'd2) begin
                        state_q <= S_FETCH;
                    end
                end
                S_KILL: begin
                    // Address stays put until the abandoned request returns.
                    if (BR_REQ) pc_q <= w_target;
                    if (IMEM_RDY) begin
                        addr_q  <= BR_REQ ? w_target : pc_q;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

    assign PC            = pc_q;
    assign PC_REL_SEL    = BR_REQ;
    assign PC_REL_OFFSET = BR_OFFSET;
    assign IMEM_REQ      = w_req;
    assign IMEM_ADDR     = addr_q;
    assign IF_VALID      = (cnt_q != 2'd0);
    assign IF_INST       = fifo_inst_q[rd_ptr_q];
    assign IF_PC         = fifo_addr_q[rd_ptr_q];
    assign BUSY          = w_req;

endmodule

`default_nettype wire

// File: tb/tb_thumb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_thumb_fetch_ctrl : directed vector bench for thumb_fetch_ctrl.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_thumb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BR_REQ = 1'b0;
    logic [31:0] BR_OFFSET = 32'd0;
    logic        IMEM_RDY = 1'b0;
    logic [15:0] IMEM_RDATA = 16'd0;
    logic        ID_READY = 1'b1;

    logic [31:0] PC, NPC, PC_REL_OFFSET, IMEM_ADDR, IF_PC;
    logic        PC_REL_SEL, IMEM_REQ, IF_VALID, BUSY;
    logic [15:0] IF_INST;

    // IF datapath: increment or PC-relative redirect
    assign NPC = PC + (PC_REL_SEL ? PC_REL_OFFSET : 32'd2);

    thumb_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .PC(PC), .NPC(NPC),
        .PC_REL_SEL(PC_REL_SEL), .PC_REL_OFFSET(PC_REL_OFFSET),
        .BR_REQ(BR_REQ), .BR_OFFSET(BR_OFFSET),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RDY(IMEM_RDY), .IMEM_RDATA(IMEM_RDATA),
        .IF_VALID(IF_VALID), .IF_INST(IF_INST), .IF_PC(IF_PC),
        .ID_READY(ID_READY), .BUSY(BUSY)
    );

    // Second instance for address wrap, zero-wait memory returning addr[15:0]
    logic [31:0] w_pc, w_npc, w_rel_off, w_addr, w_ifpc;
    logic        w_rel_sel, w_req, w_vld, w_busy;
    logic [15:0] w_inst;

    assign w_npc = w_pc + (w_rel_sel ? w_rel_off : 32'd2);

    thumb_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(CLK), .RST(RST), .PC(w_pc), .NPC(w_npc),
        .PC_REL_SEL(w_rel_sel), .PC_REL_OFFSET(w_rel_off),
        .BR_REQ(1'b0), .BR_OFFSET(32'd0),
        .IMEM_REQ(w_req), .IMEM_ADDR(w_addr),
        .IMEM_RDY(w_req), .IMEM_RDATA(w_addr[15:0]),
        .IF_VALID(w_vld), .IF_INST(w_inst), .IF_PC(w_ifpc),
        .ID_READY(1'b1), .BUSY(w_busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] boff;
        logic        idr;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ifpc;
        logic [15:0] e_inst;
        logic [31:0] e_pc;
        logic        e_busy;
    } vec_t;

    vec_t tv [18];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic br, input logic [31:0] boff,
                                input logic idr, input logic rdy, input logic [15:0] rdata,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic [31:0] ifpc, input logic [15:0] inst,
                                input logic [31:0] pc, input logic busy);
        vec_t v;
        v.rst = rst; v.br = br; v.boff = boff; v.idr = idr; v.rdy = rdy; v.rdata = rdata;
        v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_ifpc = ifpc;
        v.e_inst = inst; v.e_pc = pc; v.e_busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //          rst br boff          idr rdy rdata     req addr         vld ifpc         inst      pc           busy
        tv[0]  = mk(1, 0, 32'h0,        1, 0, 16'h0000,  0, 32'h00,      0, 32'h0,       16'h0000, 32'h00,      0);
        tv[1]  = mk(0, 0, 32'h0,        1, 0, 16'h0000,  0, 32'h00,      0, 32'h0,       16'h0000, 32'h00,      0);
        tv[2]  = mk(0, 0, 32'h0,        1, 1, 16'hA000,  1, 32'h00,      0, 32'h0,       16'h0000, 32'h00,      1);
        tv[3]  = mk(0, 0, 32'h0,        1, 1, 16'hA002,  1, 32'h02,      1, 32'h00,      16'hA000, 32'h02,      1);
        tv[4]  = mk(0, 0, 32'h0,        1, 1, 16'hA004,  1, 32'h04,      1, 32'h02,      16'hA002, 32'h04,      1);
        tv[5]  = mk(0, 0, 32'h0,        1, 1, 16'hA006,  1, 32'h06,      1, 32'h04,      16'hA004, 32'h06,      1);
        tv[6]  = mk(0, 0, 32'h0,        0, 1, 16'hA008,  1, 32'h08,      1, 32'h06,      16'hA006, 32'h08,      1);
        tv[7]  = mk(0, 0, 32'h0,        0, 0, 16'h0000,  0, 32'h0A,      1, 32'h06,      16'hA006, 32'h0A,      0);
        tv[8]  = mk(0, 0, 32'h0,        0, 0, 16'h0000,  0, 32'h0A,      1, 32'h06,      16'hA006, 32'h0A,      0);
        tv[9]  = mk(0, 0, 32'h0,        1, 0, 16'h0000,  0, 32'h0A,      1, 32'h06,      16'hA006, 32'h0A,      0);
        tv[10] = mk(0, 0, 32'h0,        1, 1, 16'hA00A,  1, 32'h0A,      1, 32'h08,      16'hA008, 32'h0A,      1);
        tv[11] = mk(0, 0, 32'h0,        1, 1, 16'hA00C,  1, 32'h0C,      1, 32'h0A,      16'hA00A, 32'h0C,      1);
        tv[12] = mk(0, 0, 32'h0,        1, 1, 16'hA00E,  1, 32'h0E,      1, 32'h0C,      16'hA00C, 32'h0E,      1);
        tv[13] = mk(0, 1, 32'h20,       1, 1, 16'hA010,  1, 32'h10,      1, 32'h0E,      16'hA00E, 32'h10,      1);
        tv[14] = mk(0, 0, 32'h0,        1, 1, 16'hA030,  1, 32'h30,      0, 32'h0,       16'h0000, 32'h30,      1);
        tv[15] = mk(0, 0, 32'h0,        1, 1, 16'hA032,  1, 32'h32,      1, 32'h30,      16'hA030, 32'h32,      1);
        tv[16] = mk(0, 0, 32'h0,        1, 0, 16'h0000,  1, 32'h34,      1, 32'h32,      16'hA032, 32'h34,      1);
        tv[17] = mk(0, 0, 32'h0,        1, 0, 16'h0000,  1, 32'h34,      0, 32'h0,       16'h0000, 32'h34,      1);

        RST = 1'b1;
        step();
        step();

        for (int i = 0; i < 18; i++) begin
            RST        = tv[i].rst;
            BR_REQ     = tv[i].br;
            BR_OFFSET  = tv[i].boff;
            ID_READY   = tv[i].idr;
            IMEM_RDY   = tv[i].rdy;
            IMEM_RDATA = tv[i].rdata;
            #1;
            chk($sformatf("v%0d req", i),  {31'd0, IMEM_REQ}, {31'd0, tv[i].e_req});
            chk($sformatf("v%0d addr", i), IMEM_ADDR, tv[i].e_addr);
            chk($sformatf("v%0d vld", i),  {31'd0, IF_VALID}, {31'd0, tv[i].e_vld});
            chk($sformatf("v%0d pc", i),   PC, tv[i].e_pc);
            chk($sformatf("v%0d busy", i), {31'd0, BUSY}, {31'd0, tv[i].e_busy});
            chk($sformatf("v%0d relsel", i), {31'd0, PC_REL_SEL}, {31'd0, tv[i].br});
            if (tv[i].br)
                chk($sformatf("v%0d reloff", i), PC_REL_OFFSET, tv[i].boff);
            if (tv[i].e_vld) begin
                chk($sformatf("v%0d ifpc", i), IF_PC, tv[i].e_ifpc);
                chk($sformatf("v%0d inst", i), {16'd0, IF_INST}, {16'd0, tv[i].e_inst});
            end
            step();
        end

        // Redirect while a slow fetch at 0x8 is outstanding
        BR_REQ = 1'b0; IMEM_RDY = 1'b0; ID_READY = 1'b1; RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            IMEM_RDY = 1'b1;
            IMEM_RDATA = 16'hB000 + 16'(i * 2);
            step();
        end
        IMEM_RDY = 1'b0;
        step();
        chk("kill pre addr", IMEM_ADDR, 32'h8);
        chk("kill pre pc", PC, 32'h8);
        BR_REQ = 1'b1; BR_OFFSET = 32'hFFFF_FFF8;
        step();
        BR_REQ = 1'b0; BR_OFFSET = 32'h0;
        #1;
        chk("kill addr hold", IMEM_ADDR, 32'h8);
        chk("kill req", {31'd0, IMEM_REQ}, 32'd1);
        chk("kill busy", {31'd0, BUSY}, 32'd1);
        chk("kill pc", PC, 32'h0);
        chk("kill flushed", {31'd0, IF_VALID}, 32'd0);
        step();
        chk("kill addr hold2", IMEM_ADDR, 32'h8);
        IMEM_RDY = 1'b1; IMEM_RDATA = 16'hDEAD;
        step();
        IMEM_RDY = 1'b0;
        #1;
        chk("kill drop vld", {31'd0, IF_VALID}, 32'd0);
        chk("kill refetch addr", IMEM_ADDR, 32'h0);
        chk("kill refetch req", {31'd0, IMEM_REQ}, 32'd1);
        IMEM_RDY = 1'b1; IMEM_RDATA = 16'hB100;
        step();
        IMEM_RDY = 1'b0;
        #1;
        chk("kill tgt vld", {31'd0, IF_VALID}, 32'd1);
        chk("kill tgt ifpc", IF_PC, 32'h0);
        chk("kill tgt inst", {16'd0, IF_INST}, 32'h0000_B100);
        chk("kill next addr", IMEM_ADDR, 32'h2);

        // Address wrap on the second instance
        RST = 1'b1;
        step();
        chk("wrap rst addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap rst req", {31'd0, w_req}, 32'd0);
        RST = 1'b0;
        step();
        chk("wrap a0", w_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap a1", w_addr, 32'hFFFF_FFFE);
        chk("wrap ifpc0", w_ifpc, 32'hFFFF_FFFC);
        chk("wrap inst0", {16'd0, w_inst}, 32'h0000_FFFC);
        step();
        chk("wrap a2", w_addr, 32'h0000_0000);
        chk("wrap ifpc1", w_ifpc, 32'hFFFF_FFFE);
        step();
        chk("wrap ifpc2", w_ifpc, 32'h0000_0000);
        chk("wrap vld", {31'd0, w_vld}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
